// File: rtl/hc_sr04_echo_rx_pkg.sv
// Shared definitions for the HC-SR04 echo receiver.
// Contents: FSM state encoding, echo-time to distance conversion constants,
// the error distance code and the conversion helper function.
package hc_sr04_echo_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RISE = 3'd1,
        ST_MEASURE   = 3'd2,
        ST_CALC      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // dist_mm = echo_us * 343 m/s / 2 ~= echo_us * 0.1715 ~= (echo_us * 11239) >> 16
    localparam logic [15:0] K_MM     = 16'd11239;
    localparam int          K_SHIFT  = 16;
    localparam logic [15:0] ERR_DIST = 16'hFFFF;

    // Fixed-point conversion; the product of a 16-bit time and the 14-bit
    // constant fits in 30 bits, the fractional millimetres are truncated.
    function automatic logic [15:0] us_to_mm(input logic [15:0] us);
        logic [31:0] prod;
        logic [31:0] shifted;
        prod    = {16'd0, us} * {16'd0, K_MM};
        shifted = prod >> K_SHIFT;
        return shifted[15:0];
    endfunction

endpackage

// File: rtl/hc_sr04_echo_rx_if.sv
// Control/result bundle of the HC-SR04 echo receiver.
//   start   : one-cycle arm pulse from the trigger logic
//   busy    : measurement in progress (start accepted .. result cycle)
//   valid   : one-cycle result strobe
//   err     : result is a timeout
//   echo_us : measured echo high time in microseconds
//   dist_mm : distance in millimetres, 16'hFFFF on error
// master = trigger/consumer side, slave = receiver.
interface hc_sr04_echo_rx_if;

    logic        start;
    logic        busy;
    logic        valid;
    logic        err;
    logic [15:0] echo_us;
    logic [15:0] dist_mm;

    modport master (
        output start,
        input  busy,
        input  valid,
        input  err,
        input  echo_us,
        input  dist_mm
    );

    modport slave (
        input  start,
        output busy,
        output valid,
        output err,
        output echo_us,
        output dist_mm
    );

endinterface

// File: rtl/hc_sr04_echo_rx_sync.sv
// echo_sync_edge: brings the asynchronous echo pin into the clk domain.
// Two synchroniser flops followed by one edge register stage, so the
// registered rise/fall strobes appear 3 cycles after a pin edge.
//   clk, rstn : clock, asynchronous active-low reset
//   echo      : raw echo pin
//   level     : synchronised echo level (aligned with the strobes)
//   rise/fall : one-cycle strobes on the synchronised level
module echo_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic echo,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic level_r;
    logic rise_r;
    logic fall_r;

    // Synchroniser chain and registered edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= echo;
            sync2_r <= sync1_r;
            level_r <= sync2_r;
            rise_r  <= sync2_r & ~level_r;
            fall_r  <= ~sync2_r & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/hc_sr04_echo_rx.sv
// hc_sr04_echo_rx: measures the HC-SR04 echo high time in microseconds after
// a trigger and converts it to millimetres.
//   clk, rstn : clock, asynchronous active-low reset
//   echo      : raw echo pin (asynchronous)
//   bus       : start in; busy/valid/err/echo_us/dist_mm out (all registered)
module hc_sr04_echo_rx
    import hc_sr04_echo_rx_pkg::*;
#(
    parameter int CLK_FREQ_MHZ    = 50,
    parameter int RISE_TIMEOUT_US = 2000,
    parameter int ECHO_TIMEOUT_US = 38000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              echo,
    hc_sr04_echo_rx_if.slave  bus
);

    localparam int                CYC_W    = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CLK_FREQ_MHZ - 1);
    localparam logic [15:0]       RISE_TO  = 16'(RISE_TIMEOUT_US);
    localparam logic [15:0]       ECHO_TO  = 16'(ECHO_TIMEOUT_US);

    state_e            state_r;
    state_e            next_state_s;
    logic              level_s;
    logic              rise_s;
    logic              fall_s;
    logic [CYC_W-1:0]  cyc_r;
    logic [15:0]       us_r;
    logic              tick_s;
    logic [15:0]       us_next_s;
    logic              clr_cnt_s;
    logic              cap_fall_s;
    logic              rise_to_s;
    logic              echo_to_s;
    logic [15:0]       meas_r;
    logic              busy_r;
    logic              valid_r;
    logic              err_r;
    logic [15:0]       echo_us_r;
    logic [15:0]       dist_mm_r;

    echo_sync_edge u_sync (
        .clk   (clk),
        .rstn  (rstn),
        .echo  (echo),
        .level (level_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // us_next_s is the microsecond count including this cycle's tick, so a
    // fall or timeout seen now accounts for the microsecond completing now.
    assign tick_s    = (cyc_r == CYC_LAST);
    assign us_next_s = us_r + {15'd0, tick_s};

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        next_state_s = state_r;
        clr_cnt_s    = 1'b0;
        cap_fall_s   = 1'b0;
        rise_to_s    = 1'b0;
        echo_to_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state_s = ST_WAIT_RISE;
                    clr_cnt_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_RISE: begin
                // Only a low-to-high transition arms the measurement; the
                // level qualifier guards against a stray strobe.
                if (rise_s && level_s) begin
                    next_state_s = ST_MEASURE;
                    clr_cnt_s    = 1'b1;
                end else if (us_next_s == RISE_TO) begin
                    next_state_s = ST_DONE;
                    rise_to_s    = 1'b1;
                end else begin
                    next_state_s = ST_WAIT_RISE;
                end
            end
            ST_MEASURE: begin
                // The fall strobe takes priority over a coincident timeout.
                if (fall_s) begin
                    next_state_s = ST_CALC;
                    cap_fall_s   = 1'b1;
                end else if (us_next_s == ECHO_TO) begin
                    next_state_s = ST_DONE;
                    echo_to_s    = 1'b1;
                end else begin
                    next_state_s = ST_MEASURE;
                end
            end
            ST_CALC: begin
                next_state_s = ST_DONE;
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Microsecond time base: cycle divider and microsecond counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_r <= '0;
            us_r  <= 16'd0;
        end else if (clr_cnt_s) begin
            cyc_r <= '0;
            us_r  <= 16'd0;
        end else if ((state_r == ST_WAIT_RISE) || (state_r == ST_MEASURE)) begin
            cyc_r <= tick_s ? '0 : (cyc_r + CYC_W'(1));
            us_r  <= us_next_s;
        end
    end

    // Capture of the echo time on the fall strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meas_r <= 16'd0;
        end else if (cap_fall_s) begin
            meas_r <= us_next_s;
        end
    end

    // Registered outputs; result fields change only when DONE is entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            echo_us_r <= 16'd0;
            dist_mm_r <= 16'd0;
        end else begin
            busy_r  <= (next_state_s != ST_IDLE);
            valid_r <= (next_state_s == ST_DONE);
            if (rise_to_s) begin
                err_r     <= 1'b1;
                echo_us_r <= 16'd0;
                dist_mm_r <= ERR_DIST;
            end else if (echo_to_s) begin
                err_r     <= 1'b1;
                echo_us_r <= ECHO_TO;
                dist_mm_r <= ERR_DIST;
            end else if (state_r == ST_CALC) begin
                err_r     <= 1'b0;
                echo_us_r <= meas_r;
                dist_mm_r <= us_to_mm(meas_r);
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.valid   = valid_r;
    assign bus.err     = err_r;
    assign bus.echo_us = echo_us_r;
    assign bus.dist_mm = dist_mm_r;

endmodule

// File: tb/tb_hc_sr04_echo_rx.sv
// Directed bench for hc_sr04_echo_rx.
// dut   : 1 MHz clock setting (1 cycle = 1 us), default timeouts, for the
//         long-range and timeout scenarios.
// dut_f : 50 MHz setting with short timeouts (rise 20 us, echo 40 us), for
//         sub-microsecond pulses and the fall/timeout tie.
module tb_hc_sr04_echo_rx;

    logic clk = 1'b0;
    logic rstn;
    logic echo_m;
    logic echo_f;
    int   checks = 0;
    int   errors = 0;
    int   vcnt_m = 0;
    int   vcnt_f = 0;

    hc_sr04_echo_rx_if bm ();
    hc_sr04_echo_rx_if bf ();

    hc_sr04_echo_rx #(
        .CLK_FREQ_MHZ    (1),
        .RISE_TIMEOUT_US (2000),
        .ECHO_TIMEOUT_US (38000)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .echo (echo_m),
        .bus  (bm)
    );

    hc_sr04_echo_rx #(
        .CLK_FREQ_MHZ    (50),
        .RISE_TIMEOUT_US (20),
        .ECHO_TIMEOUT_US (40)
    ) dut_f (
        .clk  (clk),
        .rstn (rstn),
        .echo (echo_f),
        .bus  (bf)
    );

    always #5 clk = ~clk;

    // Count valid pulses of each instance
    always @(posedge clk) begin
        if (bm.valid === 1'b1) vcnt_m <= vcnt_m + 1;
        if (bf.valid === 1'b1) vcnt_f <= vcnt_f + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit f);
        if (f) bf.start = 1'b1; else bm.start = 1'b1;
        @(negedge clk);
        bf.start = 1'b0;
        bm.start = 1'b0;
    endtask

    task automatic set_echo(input bit f, input logic v);
        if (f) echo_f = v; else echo_m = v;
    endtask

    // Negedges until valid is seen, bounded by budget
    task automatic wait_valid(input bit f, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((f ? bf.valid : bm.valid) !== 1'b1) && (n < budget));
    endtask

    // start, echo rises pre cycles later, stays high for high cycles
    task automatic measure(input bit f, input int pre, input int high, output int n);
        pulse_start(f);
        repeat (pre) @(negedge clk);
        set_echo(f, 1'b1);
        repeat (high) @(negedge clk);
        set_echo(f, 1'b0);
        wait_valid(f, 200, n);
    endtask

    initial begin
        int n;
        int v0;
        rstn     = 1'b0;
        echo_m   = 1'b0;
        echo_f   = 1'b0;
        bm.start = 1'b0;
        bf.start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_busy",   {31'd0, bm.busy},    32'd0);
        chk("rst_valid",  {31'd0, bm.valid},   32'd0);
        chk("rst_err",    {31'd0, bm.err},     32'd0);
        chk("rst_echo",   {16'd0, bm.echo_us}, 32'd0);
        chk("rst_dist",   {16'd0, bm.dist_mm}, 32'd0);
        chk("rst_f_valid",{31'd0, bf.valid},   32'd0);

        // 1000 us echo, rising 500 us after start
        measure(1'b0, 500, 1000, n);
        chk("t1_lat",   32'(n),              32'd5);
        chk("t1_valid", {31'd0, bm.valid},   32'd1);
        chk("t1_busy",  {31'd0, bm.busy},    32'd1);
        chk("t1_err",   {31'd0, bm.err},     32'd0);
        chk("t1_echo",  {16'd0, bm.echo_us}, 32'd1000);
        chk("t1_dist",  {16'd0, bm.dist_mm}, 32'd171);
        @(negedge clk);
        chk("t1_valid_drop", {31'd0, bm.valid}, 32'd0);
        chk("t1_busy_drop",  {31'd0, bm.busy},  32'd0);
        chk("t1_echo_hold",  {16'd0, bm.echo_us}, 32'd1000);

        // 5800 us echo
        repeat (3) @(negedge clk);
        measure(1'b0, 20, 5800, n);
        chk("t2_valid", {31'd0, bm.valid},   32'd1);
        chk("t2_err",   {31'd0, bm.err},     32'd0);
        chk("t2_echo",  {16'd0, bm.echo_us}, 32'd5800);
        chk("t2_dist",  {16'd0, bm.dist_mm}, 32'd994);

        // Echo held high past 38000 us
        repeat (3) @(negedge clk);
        pulse_start(1'b0);
        repeat (5) @(negedge clk);
        echo_m = 1'b1;
        wait_valid(1'b0, 40000, n);
        chk("t3_lat",   32'(n),              32'd38004);
        chk("t3_valid", {31'd0, bm.valid},   32'd1);
        chk("t3_err",   {31'd0, bm.err},     32'd1);
        chk("t3_echo",  {16'd0, bm.echo_us}, 32'd38000);
        chk("t3_dist",  {16'd0, bm.dist_mm}, 32'h0000FFFF);
        echo_m = 1'b0;
        repeat (10) @(negedge clk);

        // No rise within 2000 us; a second start while busy is ignored
        v0 = vcnt_m;
        pulse_start(1'b0);
        chk("t4_busy_rise", {31'd0, bm.busy}, 32'd1);
        repeat (9) @(negedge clk);
        pulse_start(1'b0);
        wait_valid(1'b0, 2500, n);
        chk("t4_lat",   32'(n),              32'd1990);
        chk("t4_valid", {31'd0, bm.valid},   32'd1);
        chk("t4_busy",  {31'd0, bm.busy},    32'd1);
        chk("t4_err",   {31'd0, bm.err},     32'd1);
        chk("t4_echo",  {16'd0, bm.echo_us}, 32'd0);
        chk("t4_dist",  {16'd0, bm.dist_mm}, 32'h0000FFFF);
        @(negedge clk);
        chk("t4_busy_fall", {31'd0, bm.busy}, 32'd0);
        repeat (2100) @(negedge clk);
        chk("t4_one_valid", 32'(vcnt_m - v0), 32'd1);

        // 50 MHz instance: echo beyond the 40 us timeout
        pulse_start(1'b1);
        repeat (20) @(negedge clk);
        echo_f = 1'b1;
        wait_valid(1'b1, 2500, n);
        chk("f_to_lat",  32'(n),              32'd2004);
        chk("f_to_err",  {31'd0, bf.err},     32'd1);
        chk("f_to_echo", {16'd0, bf.echo_us}, 32'd40);
        chk("f_to_dist", {16'd0, bf.dist_mm}, 32'h0000FFFF);
        echo_f = 1'b0;
        repeat (10) @(negedge clk);

        // Fall strobe coincident with the timeout compare: good result
        measure(1'b1, 20, 2000, n);
        chk("f_tie_valid", {31'd0, bf.valid},   32'd1);
        chk("f_tie_err",   {31'd0, bf.err},     32'd0);
        chk("f_tie_echo",  {16'd0, bf.echo_us}, 32'd40);
        chk("f_tie_dist",  {16'd0, bf.dist_mm}, 32'd6);
        repeat (3) @(negedge clk);

        // One cycle short of 40 us: partial microsecond dropped
        measure(1'b1, 20, 1999, n);
        chk("f_1999_valid", {31'd0, bf.valid},   32'd1);
        chk("f_1999_echo",  {16'd0, bf.echo_us}, 32'd39);
        chk("f_1999_dist",  {16'd0, bf.dist_mm}, 32'd6);
        repeat (3) @(negedge clk);

        // 40-cycle pulse, below 1 us
        measure(1'b1, 20, 40, n);
        chk("f_short_valid", {31'd0, bf.valid},   32'd1);
        chk("f_short_err",   {31'd0, bf.err},     32'd0);
        chk("f_short_echo",  {16'd0, bf.echo_us}, 32'd0);
        chk("f_short_dist",  {16'd0, bf.dist_mm}, 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-MEASURE aborts without valid
        pulse_start(1'b0);
        repeat (5) @(negedge clk);
        echo_m = 1'b1;
        repeat (600) @(negedge clk);
        chk("t6_busy_pre", {31'd0, bm.busy}, 32'd1);
        v0 = vcnt_m;
        rstn = 1'b0;
        #1;
        chk("t6_busy",  {31'd0, bm.busy},    32'd0);
        chk("t6_valid", {31'd0, bm.valid},   32'd0);
        chk("t6_err",   {31'd0, bm.err},     32'd0);
        chk("t6_echo",  {16'd0, bm.echo_us}, 32'd0);
        chk("t6_dist",  {16'd0, bm.dist_mm}, 32'd0);
        echo_m = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        chk("t6_no_valid", 32'(vcnt_m - v0), 32'd0);

        // Measurement after the abort
        measure(1'b0, 30, 1000, n);
        chk("t7_valid", {31'd0, bm.valid},   32'd1);
        chk("t7_err",   {31'd0, bm.err},     32'd0);
        chk("t7_echo",  {16'd0, bm.echo_us}, 32'd1000);
        chk("t7_dist",  {16'd0, bm.dist_mm}, 32'd171);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
